fifo_pop_ctrl: RTL and testbench

Consumer-side controller for the FIFO flow-control interface. It watches the FIFO's `can_pop` and `empty` flags and issues single-cycle read strobes. It captures returned words on `valid_read` into a small local buffer and presents them downstream over a ready/valid handshake. It sits between a FIFO's read port and the block that consumes its data.

---
 rtl/fifo_pop_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fifo_pop_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_ctrl.sv
// rtl/fifo_pop_ctrl.sv - FIFO consumer-side pop controller with local FWFT buffer; optional counters under POP_CTRL_STATS_EN
module fifo_pop_ctrl #(
  parameter int BITNUMBER  = 6,
  parameter int DEPTH      = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     fifo_can_pop,
  input  logic                     fifo_empty,
  input  logic [BITNUMBER-1:0]     fifo_data_out,
  input  logic                     fifo_valid_read,
  output logic                     fifo_rd,
  output logic [BITNUMBER-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     flush_done,
  output logic                     miss,
  output logic                     error
`ifdef POP_CTRL_STATS_EN
  ,
  output logic [15:0]              pop_count,
  output logic [15:0]              miss_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(RD_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  state_t                 state, state_next;
  logic [TW-1:0]          timer, timer_next, timer_inc;
  logic                   flush_pend;
  logic [BITNUMBER-1:0]   mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   push, pop, stray;

  // The timer counts cycles since the strobe (0 during ISSUE) and saturates.
  assign timer_inc = (timer == TMAX) ? timer : timer + TW'(1);

  // Any returned word is kept while there is room; a word outside WAIT or into a full buffer is an error.
  assign push  = fifo_valid_read && (occupancy != FULL);
  assign pop   = out_valid && out_ready;
  assign stray = fifo_valid_read && ((state != S_WAIT) || (occupancy == FULL));

  assign fifo_rd    = (state == S_ISSUE);
  assign flush_done = (state == S_FLUSH);
  assign out_data   = mem[rd_ptr];
  assign out_valid  = (occupancy != '0);

  // Next-state logic: flow-control flags only matter in IDLE; a word landing on the deadline cycle still counts.
  always_comb begin
    state_next = state;
    timer_next = timer;
    miss       = 1'b0;
    case (state)
      S_IDLE: begin
        timer_next = '0;
        if (flush || flush_pend) begin
          state_next = S_FLUSH;
        end else if (enable && fifo_can_pop && !fifo_empty && (occupancy != FULL)) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_next = timer_inc;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_next = timer_inc;
        if (fifo_valid_read) begin
          state_next = S_IDLE;
        end else if (timer == TMAX) begin
          miss       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        timer_next = '0;
        state_next = S_IDLE;
      end
      default: begin
        timer_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // A flush seen mid-read is remembered until the FSM gets back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend <= 1'b0;
    end else if (state == S_FLUSH) begin
      flush_pend <= 1'b0;
    end else if (flush && ((state == S_ISSUE) || (state == S_WAIT))) begin
      flush_pend <= 1'b1;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (stray) begin
      error <= 1'b1;
    end
  end

  // Circular first-word-fall-through buffer; flush clears pointers and overrides any push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (state == S_FLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fifo_data_out;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef POP_CTRL_STATS_EN
  logic capture;
  assign capture = (state == S_WAIT) && fifo_valid_read && (occupancy != FULL);

  // Saturating counters of captured words and timeouts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_count  <= '0;
      miss_count <= '0;
    end else begin
      if (capture && (pop_count != 16'hFFFF)) pop_count <= pop_count + 16'd1;
      if (miss && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb/tb_fifo_pop_ctrl.sv - self-checking bench for fifo_pop_ctrl
module tb_fifo_pop_ctrl;
  localparam int BW = 6;
  localparam int DP = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, enable = 1'b0, flush = 1'b0, fifo_can_pop = 1'b1, out_ready = 1'b0;
  logic          fifo_empty, fifo_valid_read, fifo_rd, out_valid, flush_done, miss, error;
  logic [BW-1:0] fifo_data_out, out_data;
  logic [2:0]    occupancy;
`ifdef POP_CTRL_STATS_EN
  logic [15:0]   pop_count, miss_count;
`endif

  fifo_pop_ctrl #(.BITNUMBER(BW), .DEPTH(DP), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_can_pop(fifo_can_pop), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_valid_read(fifo_valid_read),
    .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy), .flush_done(flush_done),
    .miss(miss), .error(error)
`ifdef POP_CTRL_STATS_EN
    , .pop_count(pop_count), .miss_count(miss_count)
`endif
  );

  // FIFO model: returns the popped word two edges after it samples fifo_rd.
  logic [BW-1:0] fm_mem [64];
  logic [5:0]    fm_wr = '0, fm_rd = '0;
  bit            fm_noreturn = 0;
  logic          rd_seen = 1'b0, st1 = 1'b0, fm_vr = 1'b0, inj_vr = 1'b0;
  logic [BW-1:0] st1_data = '0, fm_dout = '0, inj_data = '0;

  assign fifo_empty      = (fm_rd == fm_wr);
  assign fifo_valid_read = fm_vr | inj_vr;
  assign fifo_data_out   = inj_vr ? inj_data : fm_dout;

  always @(negedge clk) rd_seen = fifo_rd;

  always @(posedge clk) begin
    #1;
    fm_vr   = st1;
    fm_dout = st1_data;
    st1     = 1'b0;
    if (rd_seen) begin
      st1_data = fm_mem[fm_rd];
      fm_rd    = fm_rd + 6'd1;
      st1      = !fm_noreturn;
    end
  end

  // Behavioural model: m_age = cycles since the outstanding strobe, -1 when none.
  logic [BW-1:0] mq[$];
  int            m_age = -1;
  bit            m_flushing = 0, m_freq = 0, m_err = 0;

  always @(posedge clk) begin : model_upd
    int sz;
    bit full, vr;
    if (reset) begin
      mq.delete();
      m_age = -1; m_flushing = 0; m_freq = 0; m_err = 0;
    end else begin
      sz   = mq.size();
      full = (sz == DP);
      vr   = fifo_valid_read;
      if (vr && (m_age < 1 || full)) m_err = 1;
      if (m_flushing) mq.delete();
      else begin
        if (sz > 0 && out_ready) void'(mq.pop_front());
        if (vr && !full) mq.push_back(fifo_data_out);
      end
      if (m_flushing) m_flushing = 0;
      else if (m_age < 0) begin
        if (flush || m_freq) begin m_flushing = 1; m_freq = 0; end
        else if (enable && fifo_can_pop && !fifo_empty && sz < DP) m_age = 0;
      end else begin
        if (flush) m_freq = 1;
        if (m_age >= 1 && (vr || m_age == TO)) m_age = -1;
        else m_age++;
      end
    end
  end

  int total = 0, bad = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_fifo_rd", 32'(fifo_rd), 32'(m_age == 0));
      check("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("m_occupancy", 32'(occupancy), 32'(mq.size()));
      if (mq.size() > 0) check("m_out_data", 32'(out_data), 32'(mq[0]));
      check("m_flush_done", 32'(flush_done), 32'(m_flushing));
      check("m_miss", 32'(miss), 32'(m_age == TO && !fifo_valid_read));
      check("m_error", 32'(error), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [BW-1:0] d);
    fm_mem[fm_wr] = d;
    fm_wr = fm_wr + 6'd1;
  endtask

  initial begin : stim
    int rdn, maxo, idx, found;
    int rds[$], misses[$];
    logic [BW-1:0] seen[$];
    logic [15:0] pc;

    load(6'h15); load(6'h2A);
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    check("rst_fifo_rd", 32'(fifo_rd), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_flags", 32'({flush_done, miss, error}), 0);
    reset = 1'b0;

    // enable low: no strobes even though the FIFO has data
    rdn = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (fifo_rd) rdn++; end
    check("disabled_strobes", 32'(rdn), 0);

    // two words streamed through with out_ready high
    tick(); enable = 1'b1; out_ready = 1'b1;
    rdn = 0; maxo = 0; seen.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fifo_rd) rdn++;
      if (out_valid) seen.push_back(out_data);
      if (occupancy > maxo) maxo = int'(occupancy);
    end
    check("two_strobes", 32'(rdn), 2);
    check("two_seen", 32'(seen.size()), 2);
    if (seen.size() == 2) begin
      check("word0", 32'(seen[0]), 32'h15);
      check("word1", 32'(seen[1]), 32'h2A);
    end
    check("peak_occ", 32'(maxo), 1);

    // back-pressure: six words, room for four
    tick(); out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) load(BW'(i));
    rdn = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (fifo_rd) rdn++; end
    check("full_strobes", 32'(rdn), 4);
    check("full_occ", 32'(occupancy), 4);
    tick(); out_ready = 1'b1;
    rdn = 0; seen.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_rd) rdn++;
      if (out_valid && out_ready) seen.push_back(out_data);
    end
    check("drain_strobes", 32'(rdn), 2);
    check("drain_count", 32'(seen.size()), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) check("drain_order", 32'(seen[i]), 32'(i + 1));
    check("drain_occ", 32'(occupancy), 0);

    // timeout: FIFO never answers
    tick(); fm_noreturn = 1; load(6'h33); load(6'h0C);
    rds.delete(); misses.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_rd) rds.push_back(i);
      if (miss) misses.push_back(i);
    end
    check("miss_strobes", 32'(rds.size()), 2);
    check("miss_pulses", 32'(misses.size()), 2);
    if (rds.size() == 2 && misses.size() == 2) begin
      check("miss_latency0", 32'(misses[0] - rds[0]), 4);
      check("reissue_gap", 32'(rds[1] - misses[0]), 2);
      check("miss_latency1", 32'(misses[1] - rds[1]), 4);
    end
    tick(); fm_noreturn = 0;

    // flush during WAIT with three words held
    out_ready = 1'b0;
    load(6'h11); load(6'h22); load(6'h33);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin @(negedge clk); if (occupancy == 3'd3) found = 1; end
    check("occ3_reached", 32'(found), 1);
    tick(); load(6'h3F);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (fifo_rd) found = 1; end
    check("flush_rd_seen", 32'(found), 1);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (flush_done) found = 1; end
    check("flush_done_seen", 32'(found), 1);
    check("flush_occ_before", 32'(occupancy), 4);
    @(negedge clk);
    check("flush_occ_after", 32'(occupancy), 0);

    // stray valid_read in IDLE
`ifdef POP_CTRL_STATS_EN
    pc = pop_count;
`else
    pc = '0;
`endif
    tick(); inj_vr = 1'b1; inj_data = 6'h2C;
    tick(); inj_vr = 1'b0;
    @(negedge clk);
    check("stray_error", 32'(error), 1);
    check("stray_occ", 32'(occupancy), 1);
    check("stray_data", 32'(out_data), 32'h2C);
`ifdef POP_CTRL_STATS_EN
    check("stray_pop_count", 32'(pop_count), 32'(pc));
`endif
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    repeat (4) @(negedge clk);
    check("error_sticky", 32'(error), 1);
    check("error_flush_occ", 32'(occupancy), 0);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("error_reset", 32'(error), 0);

    // reset in the middle of a read: the late word is stray
    out_ready = 1'b1; load(6'h2B);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); if (fifo_rd) found = 1; end
    check("midrd_rd_seen", 32'(found), 1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrd_error", 32'(error), 1);
    check("midrd_data", 32'(out_data), 32'h2B);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
